// File: rtl/gate_reset_driver.sv
// gate_reset_driver: turns scan-engine row-reset requests into gate-driver STV/CPV/OE
// signalling, positioning the gate token on the target row and replaying the pulse width on OE.
`default_nettype none

module gate_reset_driver #(
  parameter int NUM_ROWS = 2048,
  parameter int ADDR_W   = 12,
  parameter int CPV_HALF = 4,
  parameter int WIDTH_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scan_mode,
  input  logic [ADDR_W-1:0] row_addr,
  input  logic              reset_pulse,
  output logic              gate_stv,
  output logic              gate_cpv,
  output logic              gate_oe,
  output logic              busy,
  output logic              done,
  output logic              addr_err,
  output logic              overrun,
  output logic [ADDR_W-1:0] token_pos
);

  localparam int CNT_W = $clog2(2 * CPV_HALF) + 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(2 * CPV_HALF - 1);
  localparam logic [CNT_W-1:0] C_HALF = CNT_W'(CPV_HALF);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_SHIFT = 2'd2,
    S_FIRE  = 2'd3
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [ADDR_W-1:0]   r_target;
  logic                r_tok_valid;
  logic                r_prev;
  logic                r_meas;
  logic                r_wfinal;
  logic [WIDTH_W-1:0]  r_wcnt;
  logic [WIDTH_W-1:0]  r_ocnt;

  logic                w_rise;
  logic                w_addr_ok;
  logic [WIDTH_W-1:0]  w_wmin;
  logic [ADDR_W-1:0]   w_tok_next;

  assign w_rise     = reset_pulse & ~r_prev;
  assign w_addr_ok  = (int'(row_addr) < NUM_ROWS);
  assign w_wmin     = (r_wcnt == '0) ? WIDTH_W'(1) : r_wcnt;
  assign w_tok_next = token_pos + ADDR_W'(1);

  // Gate outputs are a registered image of the state being left, which adds the
  // one-cycle offset between request acceptance and the first STV/CPV/OE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_target    <= '0;
      r_tok_valid <= 1'b0;
      r_prev      <= 1'b0;
      r_meas      <= 1'b0;
      r_wfinal    <= 1'b0;
      r_wcnt      <= '0;
      r_ocnt      <= '0;
      gate_stv    <= 1'b0;
      gate_cpv    <= 1'b0;
      gate_oe     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      addr_err    <= 1'b0;
      overrun     <= 1'b0;
      token_pos   <= '0;
    end else begin
      r_prev   <= reset_pulse;
      done     <= 1'b0;
      addr_err <= 1'b0;
      overrun  <= 1'b0;

      if (r_meas) begin
        if (reset_pulse) begin
          if (r_wcnt != '1) r_wcnt <= r_wcnt + WIDTH_W'(1);
        end else begin
          r_wfinal <= 1'b1;
          r_meas   <= 1'b0;
        end
      end

      if (!scan_mode) begin
        r_state     <= S_IDLE;
        r_tok_valid <= 1'b0;
        r_meas      <= 1'b0;
        gate_stv    <= 1'b0;
        gate_cpv    <= 1'b0;
        gate_oe     <= 1'b0;
        busy        <= 1'b0;
      end else begin
        if (w_rise && (r_state != S_IDLE)) overrun <= 1'b1;

        case (r_state)
          S_IDLE: begin
            gate_stv <= 1'b0;
            gate_cpv <= 1'b0;
            gate_oe  <= 1'b0;
            if (w_rise) begin
              if (!w_addr_ok) begin
                addr_err <= 1'b1;
              end else begin
                r_target <= row_addr;
                r_cnt    <= '0;
                r_ocnt   <= '0;
                r_wcnt   <= WIDTH_W'(1);
                r_wfinal <= 1'b0;
                r_meas   <= 1'b1;
                busy     <= 1'b1;
                if (r_tok_valid && (row_addr >= token_pos))
                  r_state <= (row_addr == token_pos) ? S_FIRE : S_SHIFT;
                else
                  r_state <= S_START;
              end
            end
          end

          S_START: begin
            gate_stv <= 1'b1;
            gate_cpv <= (r_cnt < C_HALF);
            gate_oe  <= 1'b0;
            if (r_cnt == C_LAST) begin
              r_cnt       <= '0;
              token_pos   <= '0;
              r_tok_valid <= 1'b1;
              r_state     <= (r_target == '0) ? S_FIRE : S_SHIFT;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end

          S_SHIFT: begin
            gate_stv <= 1'b0;
            gate_cpv <= (r_cnt < C_HALF);
            gate_oe  <= 1'b0;
            if (r_cnt == C_LAST) begin
              r_cnt     <= '0;
              token_pos <= w_tok_next;
              if (w_tok_next == r_target) r_state <= S_FIRE;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end

          S_FIRE: begin
            gate_stv <= 1'b0;
            gate_cpv <= 1'b0;
            if (r_wfinal && (r_ocnt >= w_wmin)) begin
              gate_oe <= 1'b0;
              done    <= 1'b1;
              busy    <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              gate_oe <= 1'b1;
              r_ocnt  <= r_ocnt + WIDTH_W'(1);
            end
          end

          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gate_reset_driver.sv
// tb_gate_reset_driver: scoreboard bench; each request pushes its expected OE timing,
// token position and STV/CPV activity, checked when the DUT pulses done.
`default_nettype none

module tb_gate_reset_driver;

  localparam int ADDR_W = 12;
  localparam int HALF   = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              scan_mode = 1'b1;
  logic [ADDR_W-1:0] row_addr = '0;
  logic              reset_pulse = 1'b0;
  logic              gate_stv, gate_cpv, gate_oe, busy, done, addr_err, overrun;
  logic [ADDR_W-1:0] token_pos;

  gate_reset_driver #(
    .NUM_ROWS(2048), .ADDR_W(ADDR_W), .CPV_HALF(HALF), .WIDTH_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .scan_mode(scan_mode), .row_addr(row_addr),
    .reset_pulse(reset_pulse), .gate_stv(gate_stv), .gate_cpv(gate_cpv),
    .gate_oe(gate_oe), .busy(busy), .done(done), .addr_err(addr_err),
    .overrun(overrun), .token_pos(token_pos)
  );

  always #5 clk = ~clk;

  typedef struct {
    int start;
    int w;
    int pos;
    int stv;
    int cpv;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_total = 0, n_bad = 0;
  int   n_exp = 0, n_done = 0, n_aerr = 0, n_ovr = 0, n_idle_gate = 0;
  int   oe_start = 0, oe_len = 0, stv_cnt = 0, cpv_cnt = 0;
  logic p_oe = 1'b0, p_cpv = 1'b0;
  bit   m_valid = 1'b0;
  int   m_pos = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input longint got, input longint exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor: samples outputs on the falling edge, i.e. in the cycle labelled by cyc.
  always @(negedge clk) begin
    if (!rst_n) begin
      oe_len = 0; stv_cnt = 0; cpv_cnt = 0; p_oe = 1'b0; p_cpv = 1'b0;
    end else begin
      if (gate_oe && !p_oe) oe_start = cyc;
      if (gate_oe) oe_len++;
      if (gate_stv) stv_cnt++;
      if (gate_cpv && !p_cpv) cpv_cnt++;
      if (addr_err) n_aerr++;
      if (overrun) n_ovr++;
      if (!busy && (gate_stv || gate_cpv || gate_oe)) n_idle_gate++;
      if (done) begin
        exp_t e;
        n_done++;
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("oe_start", oe_start, e.start);
          check("oe_width", oe_len, e.w);
          check("token_pos", token_pos, e.pos);
          check("stv_cycles", stv_cnt, e.stv);
          check("cpv_pulses", cpv_cnt, e.cpv);
        end
        oe_len = 0; stv_cnt = 0; cpv_cnt = 0;
      end else if (!busy) begin
        oe_len = 0; stv_cnt = 0; cpv_cnt = 0;
      end
      p_oe  = gate_oe;
      p_cpv = gate_cpv;
    end
  end

  task automatic send(input int addr, input int w, input bit track);
    exp_t e;
    int   k;
    @(negedge clk);
    row_addr    = ADDR_W'(addr);
    reset_pulse = 1'b1;
    k = cyc + 1;
    if (track) begin
      if (m_valid && addr >= m_pos) begin
        e.start = k + 1 + 2 * HALF * (addr - m_pos);
        e.stv   = 0;
        e.cpv   = addr - m_pos;
      end else begin
        e.start = k + 1 + 2 * HALF * (addr + 1);
        e.stv   = 2 * HALF;
        e.cpv   = addr + 1;
      end
      e.w   = w;
      e.pos = addr;
      sb.push_back(e);
      n_exp++;
      m_valid = 1'b1;
      m_pos   = addr;
    end
    repeat (w) @(negedge clk);
    reset_pulse = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", busy, 0);
    @(negedge clk);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_stv", gate_stv, 0);
    check("rst_cpv", gate_cpv, 0);
    check("rst_oe", gate_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_token", token_pos, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    send(0, 100, 1);  wait_idle(300);
    send(3, 20, 1);   wait_idle(300);
    send(1, 10, 1);   wait_idle(300);

    send(2048, 2, 0);
    repeat (5) @(negedge clk);
    check("aerr_count", n_aerr, 1);
    check("aerr_busy", busy, 0);

    send(20, 4, 1);
    repeat (10) @(negedge clk);
    reset_pulse = 1'b1;
    repeat (2) @(negedge clk);
    reset_pulse = 1'b0;
    wait_idle(400);
    check("overrun_count", n_ovr, 1);

    send(500, 3, 0);
    repeat (40) @(negedge clk);
    scan_mode = 1'b0;
    @(negedge clk);
    check("abort_stv", gate_stv, 0);
    check("abort_cpv", gate_cpv, 0);
    check("abort_oe", gate_oe, 0);
    check("abort_busy", busy, 0);
    scan_mode = 1'b1;
    m_valid = 1'b0;
    repeat (3) @(negedge clk);

    send(5, 6, 1);    wait_idle(300);

    // Rise coincident with scan_mode low: no request, no error, token dropped.
    @(negedge clk);
    scan_mode = 1'b0; row_addr = ADDR_W'(2048); reset_pulse = 1'b1;
    @(negedge clk);
    scan_mode = 1'b1;
    @(negedge clk);
    check("nomode_busy", busy, 0);
    check("nomode_aerr", n_aerr, 1);
    reset_pulse = 1'b0;
    m_valid = 1'b0;
    repeat (2) @(negedge clk);

    send(10, 3, 1);   wait_idle(300);

    send(2, 3, 0);
    n = 0;
    while (!gate_oe && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("fire_reached", gate_oe, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_oe", gate_oe, 0);
    check("arst_busy", busy, 0);
    check("arst_stv", gate_stv, 0);
    check("arst_token", token_pos, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_valid = 1'b0;
    repeat (3) @(negedge clk);

    check("done_count", n_done, n_exp);
    check("sb_empty", sb.size(), 0);
    check("idle_gate_activity", n_idle_gate, 0);
    check("overrun_final", n_ovr, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
